// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a 2-flop synchronizer, start-glitch rejection and parity/framing flags.
// Frame result appears 1 clock after the final stop sample; there is no backpressure, so o_done_bit must be consumed when it pulses.
module uart_rx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic            i_rx_data_input,
  output logic            o_done_bit,
  output logic [DBIT-1:0] o_data_byte,
  output logic            o_parity_err,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int SMAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);
  localparam logic          PAR_ON = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            perr_q, perr_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            perr_out_q, perr_out_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            rx_s;

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], i_rx_data_input};

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_q == S_MID) begin
            // A start bit that is high again at its midpoint was noise.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = PAR_ON ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (i_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            perr_d  = (^b_q) ^ rx_s ^ ODD;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_q == S_STOP) begin
            data_d     = b_q;
            ferr_d     = ~rx_s;
            perr_out_d = PAR_ON & perr_q;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
    end
  end

  assign o_done_bit   = done_q;
  assign o_data_byte  = data_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7-bit/2-stop) fed serial frames; results scoreboarded on done.
module tb_uart_rx_param;

  localparam int TICK_DIV = 3;

  logic clk = 1'b0;
  logic rst;
  logic tick = 1'b0;
  logic rx_a, rx_b, rx_c;
  logic done_a, perr_a, ferr_a, busy_a;
  logic done_b, perr_b, ferr_b, busy_b;
  logic done_c, perr_c, ferr_c, busy_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  int tick_cnt = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [8:0] data;
    bit         perr;
    bit         ferr;
  } exp_t;

  typedef struct {
    int         which;
    logic [8:0] data;
    bit         par;
    bit         stop_val;
    int         gap;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  uart_rx_param dut_a (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx_a),
    .o_done_bit(done_a), .o_data_byte(data_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_busy(busy_a)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx_b),
    .o_done_bit(done_b), .o_data_byte(data_b), .o_parity_err(perr_b),
    .o_frame_err(ferr_b), .o_busy(busy_b)
  );

  uart_rx_param #(.DBIT(7), .STOP_TICKS(32)) dut_c (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx_c),
    .o_done_bit(done_c), .o_data_byte(data_c), .o_parity_err(perr_c),
    .o_frame_err(ferr_c), .o_busy(busy_c)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_cnt <= (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
    tick     <= (tick_cnt == TICK_DIV - 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    #1;
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Start bit, data LSB first, and parity when the target receiver expects it.
  task automatic send_head(input int which, input logic [8:0] data, input bit par);
    int nbits = (which == 2) ? 7 : 8;
    set_rx(which, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, data[i]);
      wait_ticks(16);
    end
    if (which == 1) begin
      set_rx(which, par);
      wait_ticks(16);
    end
  endtask

  // A low stop bit is released 4 ticks early so the idle line is high again before the re-armed start midpoint.
  task automatic send_frame(input int which, input logic [8:0] data, input bit par, input bit stop_val);
    int st = (which == 2) ? 32 : 16;
    send_head(which, data, par);
    if (stop_val) begin
      set_rx(which, 1'b1);
      wait_ticks(st);
    end else begin
      set_rx(which, 1'b0);
      wait_ticks(st - 4);
      set_rx(which, 1'b1);
      wait_ticks(4);
    end
  endtask

  task automatic push_exp(input int which, input logic [8:0] d, input bit pe, input bit fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    case (which)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic mon_check(input string tag, input int which, input logic [8:0] data,
                           input logic perr, input logic ferr, input logic busy);
    exp_t e;
    checks++;
    if (q_size(which) == 0) begin
      errors++;
      $display("FAIL %s_unexpected_done: done pulsed with data 0x%0h, expected no frame", tag, data);
      return;
    end
    case (which)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
    chk({tag, "_data"}, 32'(data), 32'(e.data));
    chk({tag, "_perr"}, 32'(perr), 32'(e.perr));
    chk({tag, "_ferr"}, 32'(ferr), 32'(e.ferr));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (done_a === 1'b1) mon_check("a", 0, {1'b0, data_a}, perr_a, ferr_a, busy_a);
    if (done_b === 1'b1) mon_check("b", 1, {1'b0, data_b}, perr_b, ferr_b, busy_b);
    if (done_c === 1'b1) mon_check("c", 2, {2'b0, data_c}, perr_c, ferr_c, busy_c);
  end

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 9'h055, 1'b0, 1'b1, 8,  9'h055, 1'b0, 1'b0};
    tbl[1] = '{0, 9'h0A3, 1'b0, 1'b1, 0,  9'h0A3, 1'b0, 1'b0};
    tbl[2] = '{0, 9'h00F, 1'b0, 1'b1, 8,  9'h00F, 1'b0, 1'b0};
    tbl[3] = '{0, 9'h0FF, 1'b0, 1'b0, 16, 9'h0FF, 1'b0, 1'b1};
    tbl[4] = '{0, 9'h03C, 1'b0, 1'b1, 8,  9'h03C, 1'b0, 1'b0};
    tbl[5] = '{1, 9'h007, 1'b1, 1'b1, 8,  9'h007, 1'b0, 1'b0};
    tbl[6] = '{1, 9'h007, 1'b0, 1'b1, 8,  9'h007, 1'b1, 1'b0};
    tbl[7] = '{1, 9'h0E5, 1'b1, 1'b1, 8,  9'h0E5, 1'b0, 1'b0};
    tbl[8] = '{1, 9'h0E5, 1'b1, 1'b0, 16, 9'h0E5, 1'b0, 1'b1};
    tbl[9] = '{2, 9'h025, 1'b0, 1'b1, 8,  9'h025, 1'b0, 1'b0};

    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_data_a", 32'(data_a), 32'd0);
    chk("rst_perr_a", 32'(perr_a), 32'd0);
    chk("rst_ferr_a", 32'(ferr_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_data_b", 32'(data_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_data_c", 32'(data_c), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(4);

    for (int i = 0; i < 10; i++) begin
      push_exp(tbl[i].which, tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr);
      send_frame(tbl[i].which, tbl[i].data, tbl[i].par, tbl[i].stop_val);
      if (tbl[i].gap > 0) begin
        wait_ticks(tbl[i].gap);
        @(negedge clk);
        chk($sformatf("vec%0d_drained", i), 32'(q_size(tbl[i].which)), 32'd0);
        chk($sformatf("vec%0d_busy_idle", i),
            32'((tbl[i].which == 0) ? busy_a : (tbl[i].which == 1) ? busy_b : busy_c), 32'd0);
      end
    end

    // Start glitch: 4 ticks low must not produce a frame or disturb the held data.
    set_rx(0, 1'b0);
    wait_ticks(2);
    @(negedge clk);
    chk("glitch_busy_high", 32'(busy_a), 32'd1);
    wait_ticks(2);
    set_rx(0, 1'b1);
    wait_ticks(16);
    @(negedge clk);
    chk("glitch_busy_low", 32'(busy_a), 32'd0);
    chk("glitch_data_held", 32'(data_a), 32'h3C);

    // Reset in the middle of data bit 4, then a clean frame.
    set_rx(0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, 1'(i % 2));
      wait_ticks(16);
    end
    set_rx(0, 1'b1);
    wait_ticks(8);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_data", 32'(data_a), 32'd0);
    chk("midrst_ferr", 32'(ferr_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(16);
    push_exp(0, 9'h0C3, 1'b0, 1'b0);
    send_frame(0, 9'h0C3, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_drained", 32'(q_a.size()), 32'd0);

    // 7 data bits with 32 stop ticks: done must wait for the second stop bit.
    push_exp(2, 9'h05A, 1'b0, 1'b0);
    send_head(2, 9'h05A, 1'b0);
    set_rx(2, 1'b1);
    wait_ticks(16);
    @(negedge clk);
    chk("c_no_done_after_16_stop", 32'(q_c.size()), 32'd1);
    chk("c_busy_in_stop", 32'(busy_c), 32'd1);
    wait_ticks(16);
    @(negedge clk);
    chk("c_done_after_32_stop", 32'(q_c.size()), 32'd0);
    chk("c_data_held", 32'(data_c), 32'h5A);

    wait_ticks(8);
    @(negedge clk);
    chk("final_q_a", 32'(q_a.size()), 32'd0);
    chk("final_q_b", 32'(q_b.size()), 32'd0);
    chk("final_q_c", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
